id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline register with operand forwarding and load-use hazard detection for the 5-stage RV32 core. It captures decoded instructions and drives the execute-stage ALU operands A/B (3-bit ALUControl encoding: 000 add, 001 sub, 010 and, 011 or, 101 slt, 110 sll). Bypass values come from the EX/MEM and MEM/WB stages. It stalls decode on load-use hazards and inserts bubbles on stall or branch flush.

## Interface
- XLEN, 32, datapath width
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- d_valid  in  1  decode slot holds a real instruction
- d_rs1, d_rs2, d_rd  in  5 each  source/destination register indices
- d_rd1, d_rd2  in  XLEN each  register-file read data
- d_imm, d_pc  in  XLEN each  immediate, instruction PC
- d_alu_control  in  3  ALU op
- d_alu_src  in  1  1 = operand B from immediate
- d_result_src  in  2  00 ALU, 01 load, 10 PC+4
- d_reg_write, d_mem_write, d_branch, d_jump  in  1 each  control bits
- flush_e  in  1  taken branch/jump resolved in EX; kill the decode slot
- m_rd  in  5; m_reg_write  in  1; m_alu_result  in  XLEN  EX/MEM bypass source
- w_rd  in  5; w_reg_write  in  1; w_result  in  XLEN  MEM/WB bypass source
- e_src_a, e_src_b  out  XLEN each  ALU operands A/B
- e_write_data  out  XLEN  forwarded rs2, used as store data
- e_alu_control  out  3; e_result_src  out  2; e_rd  out  5; e_pc, e_imm  out  XLEN
- e_valid, e_reg_write, e_mem_write, e_branch, e_jump  out  1 each
- stall_d  out  1  hold PC and IF/ID this cycle
- stall_count  out  32  count of load-use stall cycles

## Operation
- Registered fields: valid, rs1, rs2, rd, rd1, rd2, imm, pc, alu_control, alu_src, result_src, and the four control bits.
- load_use = e_valid & (e_result_src==01) & (e_rd!=0) & d_valid & (d_rs1==e_rd | d_rs2==e_rd).
- stall_d = load_use & ~flush_e. This signal is combinational.
- Bubble: all registered fields load 0 (valid=0, all write enables 0, rd=0).
- Per-edge priority:
  - reset → bubble, stall_count=0.
  - flush_e → bubble.
  - load_use → bubble, stall_count+1.
  - otherwise, capture the d_* inputs. If d_valid=0, capture as a bubble.
- stall_count wraps 0xFFFFFFFF→0. It counts only cycles where stall_d=1.
- Forward A, using the registered rs1:
  - if m_reg_write & m_rd!=0 & m_rd==e_rs1 → m_alu_result.
  - elif w_reg_write & w_rd!=0 & w_rd==e_rs1 → w_result.
  - else → registered rd1.
- Forward B: same rules on rs2/rd2 → e_write_data. MEM always beats WB.
- e_src_a = forwarded A. e_src_b = e_alu_src ? e_imm : e_write_data.
- x0 is never forwarded. Reads of rs=0 return the registered rd1/rd2, which the register file guarantees is 0.
- No arithmetic on data beyond muxing. Widths are passed through unchanged.

## Timing
- Latency: d_* valid before edge N → e_* visible after edge N (1 cycle).
- Forward muxes and stall_d are combinational, within the same cycle as their inputs.
- Reset values:
  - all e_* registered outputs = 0, e_valid=0, stall_count=0, stall_d=0.
  - e_src_a = e_src_b = e_write_data = 0 while bypass write enables are low.
- Load-use: the load sits in EX in cycle N, so stall_d=1 in N. A bubble enters EX at edge N. The dependent instruction is re-presented in N+1 and captured at edge N+1 with stall_d=0. It then receives the load data via the WB path (the load is in WB at N+2 when the consumer is in EX).
- flush_e with load_use in the same cycle: the flush wins. stall_d=0 and stall_count is unchanged.
- Reset during a stall: the bubble is loaded, stall_d drops next cycle, and the counter clears.
- Back-to-back loads feeding each other each stall exactly 1 cycle.

## Test plan
- Reset: hold reset 2 cycles with random d_* inputs → every e_* output is 0, e_valid=0, stall_count=0.
- EX-EX forward: m_rd=5, m_reg_write=1, m_alu_result=0x11, w_rd=5, w_result=0x22, registered rs1=5 → e_src_a=0x11. With m_reg_write=0 → e_src_a=0x22.
- x0 guard: m_rd=0, m_reg_write=1, m_alu_result=0xDEAD, registered rs1=0, rd1=0 → e_src_a=0.
- Load-use: a load (rd=7) in EX, decode d_rs2=7 with d_valid=1 → stall_d=1 for exactly 1 cycle. The next e_valid=0, then the instruction is captured, and stall_count=1.
- Flush: flush_e=1 while d_valid=1 with add x3,x1,x2 → after the edge e_valid=0 and e_reg_write=0. With flush_e and load_use both high → stall_d=0 and stall_count is unchanged.
- Immediate select: d_alu_src=1, d_imm=0xFFFFFFF0, forwarded rs2=0x5 → e_src_b=0xFFFFFFF0 and e_write_data=0x5.

Source files
------------

// File: rtl/id_ex_if.sv
// Signal bundle between decode, the ID/EX register and the bypass sources.
// The slave side is the id_ex_stage. The master side is the surrounding pipeline or a bench.
interface id_ex_if #(parameter int XLEN = 32);
  logic            d_valid;
  logic [4:0]      d_rs1, d_rs2, d_rd;
  logic [XLEN-1:0] d_rd1, d_rd2, d_imm, d_pc;
  logic [2:0]      d_alu_control;
  logic            d_alu_src;
  logic [1:0]      d_result_src;
  logic            d_reg_write, d_mem_write, d_branch, d_jump;
  logic            flush_e;

  logic [4:0]      m_rd;
  logic            m_reg_write;
  logic [XLEN-1:0] m_alu_result;
  logic [4:0]      w_rd;
  logic            w_reg_write;
  logic [XLEN-1:0] w_result;

  logic [XLEN-1:0] e_src_a, e_src_b, e_write_data;
  logic [2:0]      e_alu_control;
  logic [1:0]      e_result_src;
  logic [4:0]      e_rd;
  logic [XLEN-1:0] e_pc, e_imm;
  logic            e_valid, e_reg_write, e_mem_write, e_branch, e_jump;
  logic            stall_d;
  logic [31:0]     stall_count;

  modport master (
    output d_valid, d_rs1, d_rs2, d_rd, d_rd1, d_rd2, d_imm, d_pc, d_alu_control,
           d_alu_src, d_result_src, d_reg_write, d_mem_write, d_branch, d_jump, flush_e,
           m_rd, m_reg_write, m_alu_result, w_rd, w_reg_write, w_result,
    input  e_src_a, e_src_b, e_write_data, e_alu_control, e_result_src, e_rd, e_pc, e_imm,
           e_valid, e_reg_write, e_mem_write, e_branch, e_jump, stall_d, stall_count
  );

  modport slave (
    input  d_valid, d_rs1, d_rs2, d_rd, d_rd1, d_rd2, d_imm, d_pc, d_alu_control,
           d_alu_src, d_result_src, d_reg_write, d_mem_write, d_branch, d_jump, flush_e,
           m_rd, m_reg_write, m_alu_result, w_rd, w_reg_write, w_result,
    output e_src_a, e_src_b, e_write_data, e_alu_control, e_result_src, e_rd, e_pc, e_imm,
           e_valid, e_reg_write, e_mem_write, e_branch, e_jump, stall_d, stall_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV32 core. It forwards ALU operands from EX/MEM and MEM/WB,
// detects load-use hazards, and inserts bubbles on a stall or a branch flush.
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input logic   clk,
  input logic   reset,
  id_ex_if.slave bus
);

  typedef struct packed {
    logic            valid;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [2:0]      alu_control;
    logic            alu_src;
    logic [1:0]      result_src;
    logic            reg_write;
    logic            mem_write;
    logic            branch;
    logic            jump;
  } ex_t;

  ex_t         ex_q, ex_d;
  logic [31:0] stall_cnt_q;
  logic        load_use;
  logic        stall;
  logic [XLEN-1:0] fwd_a, fwd_b;

  // A load is still in EX, so its data is not available to the instruction in decode yet.
  assign load_use = ex_q.valid && (ex_q.result_src == 2'b01) && (ex_q.rd != 5'd0) &&
                    bus.d_valid && ((bus.d_rs1 == ex_q.rd) || (bus.d_rs2 == ex_q.rd));
  assign stall    = load_use && !bus.flush_e;

  always_comb begin
    ex_d = '0;
    if (!bus.flush_e && !load_use && bus.d_valid) begin
      ex_d.valid       = 1'b1;
      ex_d.rs1         = bus.d_rs1;
      ex_d.rs2         = bus.d_rs2;
      ex_d.rd          = bus.d_rd;
      ex_d.rd1         = bus.d_rd1;
      ex_d.rd2         = bus.d_rd2;
      ex_d.imm         = bus.d_imm;
      ex_d.pc          = bus.d_pc;
      ex_d.alu_control = bus.d_alu_control;
      ex_d.alu_src     = bus.d_alu_src;
      ex_d.result_src  = bus.d_result_src;
      ex_d.reg_write   = bus.d_reg_write;
      ex_d.mem_write   = bus.d_mem_write;
      ex_d.branch      = bus.d_branch;
      ex_d.jump        = bus.d_jump;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q <= ex_d;
      if (stall) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  // The younger producer (EX/MEM) takes priority over MEM/WB. x0 is never bypassed.
  always_comb begin
    fwd_a = ex_q.rd1;
    if (bus.m_reg_write && (bus.m_rd != 5'd0) && (bus.m_rd == ex_q.rs1))
      fwd_a = bus.m_alu_result;
    else if (bus.w_reg_write && (bus.w_rd != 5'd0) && (bus.w_rd == ex_q.rs1))
      fwd_a = bus.w_result;
  end

  always_comb begin
    fwd_b = ex_q.rd2;
    if (bus.m_reg_write && (bus.m_rd != 5'd0) && (bus.m_rd == ex_q.rs2))
      fwd_b = bus.m_alu_result;
    else if (bus.w_reg_write && (bus.w_rd != 5'd0) && (bus.w_rd == ex_q.rs2))
      fwd_b = bus.w_result;
  end

  assign bus.e_src_a       = fwd_a;
  assign bus.e_write_data  = fwd_b;
  assign bus.e_src_b       = ex_q.alu_src ? ex_q.imm : fwd_b;
  assign bus.e_alu_control = ex_q.alu_control;
  assign bus.e_result_src  = ex_q.result_src;
  assign bus.e_rd          = ex_q.rd;
  assign bus.e_pc          = ex_q.pc;
  assign bus.e_imm         = ex_q.imm;
  assign bus.e_valid       = ex_q.valid;
  assign bus.e_reg_write   = ex_q.reg_write;
  assign bus.e_mem_write   = ex_q.mem_write;
  assign bus.e_branch      = ex_q.branch;
  assign bus.e_jump        = ex_q.jump;
  assign bus.stall_d       = stall;
  assign bus.stall_count   = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage. It runs directed scenarios and then randomized traffic.
// Every output is compared against an instruction-level reference model.
module tb_id_ex_stage;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_ex_if #(.XLEN(XLEN)) bus ();
  id_ex_stage #(.XLEN(XLEN)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic        valid;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rd1, rd2, imm, pc;
    logic [2:0]  alu;
    logic        src;
    logic [1:0]  rsrc;
    logic        rw, mw, br, jp;
  } ins_t;

  ins_t        ex;
  logic [31:0] scount;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic ins_t bubble();
    ins_t b = '{default: '0};
    return b;
  endfunction

  function automatic ins_t decoded();
    ins_t i;
    i.valid = 1'b1;          i.rs1 = bus.d_rs1;   i.rs2 = bus.d_rs2;   i.rd = bus.d_rd;
    i.rd1 = bus.d_rd1;       i.rd2 = bus.d_rd2;   i.imm = bus.d_imm;   i.pc = bus.d_pc;
    i.alu = bus.d_alu_control; i.src = bus.d_alu_src; i.rsrc = bus.d_result_src;
    i.rw = bus.d_reg_write;  i.mw = bus.d_mem_write; i.br = bus.d_branch; i.jp = bus.d_jump;
    return i;
  endfunction

  // Bypass sources listed youngest first; the first live writer of the register wins.
  function automatic logic [31:0] operand(input logic [4:0] rs, input logic [31:0] rfval);
    logic        en  [2];
    logic [4:0]  dst [2];
    logic [31:0] val [2];
    en[0] = bus.m_reg_write; dst[0] = bus.m_rd; val[0] = bus.m_alu_result;
    en[1] = bus.w_reg_write; dst[1] = bus.w_rd; val[1] = bus.w_result;
    if (rs == 5'd0) return rfval;
    for (int k = 0; k < 2; k++)
      if (en[k] && dst[k] == rs) return val[k];
    return rfval;
  endfunction

  function automatic logic hazard();
    logic dep;
    dep = (bus.d_rs1 == ex.rd) || (bus.d_rs2 == ex.rd);
    return ex.valid && ex.rsrc == 2'b01 && ex.rd != 0 && bus.d_valid && dep;
  endfunction

  // One rising edge. The model advances from the inputs held across the edge.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      ex = bubble(); scount = 0;
    end else if (bus.flush_e) begin
      ex = bubble();
    end else if (hazard()) begin
      ex = bubble(); scount = scount + 1;
    end else begin
      ex = bus.d_valid ? decoded() : bubble();
    end
    #1;
  endtask

  task automatic check_all();
    logic [31:0] b;
    b = operand(ex.rs2, ex.rd2);
    check("src_a", bus.e_src_a, operand(ex.rs1, ex.rd1));
    check("write_data", bus.e_write_data, b);
    check("src_b", bus.e_src_b, ex.src ? ex.imm : b);
    check("alu_control", {29'd0, bus.e_alu_control}, {29'd0, ex.alu});
    check("result_src", {30'd0, bus.e_result_src}, {30'd0, ex.rsrc});
    check("rd", {27'd0, bus.e_rd}, {27'd0, ex.rd});
    check("pc", bus.e_pc, ex.pc);
    check("imm", bus.e_imm, ex.imm);
    check("ctrl", {27'd0, bus.e_valid, bus.e_reg_write, bus.e_mem_write, bus.e_branch, bus.e_jump},
          {27'd0, ex.valid, ex.rw, ex.mw, ex.br, ex.jp});
    check("stall_d", {31'd0, bus.stall_d}, {31'd0, hazard() && !bus.flush_e});
    check("stall_count", bus.stall_count, scount);
  endtask

  task automatic idle();
    bus.d_valid = 0; bus.d_rs1 = 0; bus.d_rs2 = 0; bus.d_rd = 0;
    bus.d_rd1 = 0; bus.d_rd2 = 0; bus.d_imm = 0; bus.d_pc = 0;
    bus.d_alu_control = 0; bus.d_alu_src = 0; bus.d_result_src = 0;
    bus.d_reg_write = 0; bus.d_mem_write = 0; bus.d_branch = 0; bus.d_jump = 0;
    bus.flush_e = 0; bus.m_rd = 0; bus.m_reg_write = 0; bus.m_alu_result = 0;
    bus.w_rd = 0; bus.w_reg_write = 0; bus.w_result = 0;
  endtask

  task automatic rand_decode();
    bus.d_valid = ($urandom_range(0, 99) < 85);
    bus.d_rs1 = 5'($urandom_range(0, 7)); bus.d_rs2 = 5'($urandom_range(0, 7));
    bus.d_rd  = 5'($urandom_range(0, 7));
    bus.d_rd1 = $urandom; bus.d_rd2 = $urandom; bus.d_imm = $urandom; bus.d_pc = $urandom;
    bus.d_alu_control = 3'($urandom_range(0, 7)); bus.d_alu_src = 1'($urandom);
    bus.d_result_src = ($urandom_range(0, 2) == 0) ? 2'b01 : 2'($urandom_range(0, 2));
    bus.d_reg_write = 1'($urandom); bus.d_mem_write = 1'($urandom);
    bus.d_branch = 1'($urandom); bus.d_jump = 1'($urandom);
  endtask

  task automatic rand_bypass();
    bus.m_rd = 5'($urandom_range(0, 7)); bus.m_reg_write = 1'($urandom); bus.m_alu_result = $urandom;
    bus.w_rd = 5'($urandom_range(0, 7)); bus.w_reg_write = 1'($urandom); bus.w_result = $urandom;
  endtask

  // Decode presents a plain ALU instruction.
  task automatic present(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [1:0] rsrc);
    bus.d_valid = 1; bus.d_rs1 = rs1; bus.d_rs2 = rs2; bus.d_rd = rd;
    bus.d_result_src = rsrc; bus.d_reg_write = 1; bus.d_alu_src = 0;
  endtask

  initial begin
    logic [31:0] saved;
    ex = bubble(); scount = 0;
    idle();

    // Hold reset for two cycles while the decode inputs are randomized.
    reset = 1;
    rand_decode(); tick();
    rand_decode(); tick();
    bus.m_reg_write = 0; bus.w_reg_write = 0; #1;
    check("rst_valid", {31'd0, bus.e_valid}, 32'd0);
    check("rst_count", bus.stall_count, 32'd0);
    check("rst_src_a", bus.e_src_a, 32'd0);
    check("rst_src_b", bus.e_src_b, 32'd0);
    check_all();
    reset = 0; idle();

    // EX/MEM beats MEM/WB, and MEM/WB beats the register file.
    present(5, 6, 9, 2'b00); bus.d_rd1 = 32'h99; tick();
    bus.m_rd = 5; bus.m_reg_write = 1; bus.m_alu_result = 32'h11;
    bus.w_rd = 5; bus.w_reg_write = 1; bus.w_result = 32'h22; bus.d_valid = 0; #1;
    check("fwd_mem", bus.e_src_a, 32'h11);
    bus.m_reg_write = 0; #1;
    check("fwd_wb", bus.e_src_a, 32'h22);
    bus.w_reg_write = 0; #1;
    check("fwd_rf", bus.e_src_a, 32'h99);

    // x0 is never forwarded.
    idle(); present(0, 0, 1, 2'b00); tick();
    bus.d_valid = 0; bus.m_rd = 0; bus.m_reg_write = 1; bus.m_alu_result = 32'hDEAD; #1;
    check("x0_guard", bus.e_src_a, 32'h0);

    // A load to x7 followed by a consumer of x7 stalls decode for exactly one cycle.
    idle(); present(1, 2, 7, 2'b01); tick();
    present(3, 7, 8, 2'b00); #1;
    check("lu_stall", {31'd0, bus.stall_d}, 32'd1);
    tick();
    check("lu_bubble", {31'd0, bus.e_valid}, 32'd0);
    check("lu_released", {31'd0, bus.stall_d}, 32'd0);
    check("lu_count", bus.stall_count, 32'd1);
    tick(); bus.d_valid = 0;
    bus.w_rd = 7; bus.w_reg_write = 1; bus.w_result = 32'hABCD; #1;
    check("lu_captured", {27'd0, bus.e_valid, bus.e_rd}, {27'd0, 1'b1, 5'd8});
    check("lu_wb_data", bus.e_write_data, 32'hABCD);
    check_all();

    // A flush kills the decode slot and also overrides a simultaneous load-use hazard.
    idle(); present(1, 2, 3, 2'b00); bus.flush_e = 1; tick();
    check("flush_valid", {30'd0, bus.e_valid, bus.e_reg_write}, 32'd0);
    bus.flush_e = 0; present(1, 2, 7, 2'b01); tick();
    saved = bus.stall_count;
    present(7, 0, 4, 2'b00); bus.flush_e = 1; #1;
    check("flush_lu_stall", {31'd0, bus.stall_d}, 32'd0);
    tick();
    check("flush_lu_count", bus.stall_count, saved);

    // Back-to-back dependent loads each stall one cycle.
    idle(); present(1, 2, 7, 2'b01); tick();
    saved = bus.stall_count;
    present(7, 0, 9, 2'b01); tick(); tick();
    present(9, 0, 10, 2'b00); #1;
    check("b2b_stall", {31'd0, bus.stall_d}, 32'd1);
    tick(); tick();
    check("b2b_count", bus.stall_count, saved + 32'd2);

    // The immediate replaces operand B. The store data keeps rs2.
    idle(); present(1, 4, 5, 2'b00); bus.d_rd2 = 32'h5;
    bus.d_alu_src = 1; bus.d_imm = 32'hFFFFFFF0; tick();
    bus.d_valid = 0; #1;
    check("imm_src_b", bus.e_src_b, 32'hFFFFFFF0);
    check("imm_wdata", bus.e_write_data, 32'h5);

    // Reset arriving during a stall clears the counter and releases decode.
    idle(); present(1, 2, 7, 2'b01); tick();
    present(7, 7, 1, 2'b00); reset = 1; tick();
    reset = 0; #1;
    check("rst_stall_d", {31'd0, bus.stall_d}, 32'd0);
    check("rst_stall_cnt", bus.stall_count, 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 99) < 2);
      bus.flush_e = ($urandom_range(0, 99) < 10);
      rand_decode();
      rand_bypass();
      #1;
      check_all();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
